layer_compositor: RTL and testbench

Parametrised, pipelined video compositor for the juggling display path. It builds a base pixel from the camera/threshold view, then blends NUM_LAYERS overlay layers on top in fixed priority order (crosshairs, trajectories, judgment marks and similar). Each layer has its own alpha and optional frame-synchronous blinking. Sits between the overlay generators and the HDMI/TMDS output stage, replacing the single-stage mux with a fixed, documented latency and sync sideband alignment.

---
 rtl/layer_compositor.sv | 149 ++++++++++++++
 tb/tb_layer_compositor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// Pipelined overlay compositor: base pixel from camera/threshold view, then NUM_LAYERS
// alpha-blended overlays, lowest priority first. Define COMPOSITOR_ALPHA_EN for true blending.
module layer_compositor #(
    parameter int NUM_LAYERS   = 4,
    parameter int ALPHA_W      = 4,
    parameter int SYNC_W       = 3,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [1:0]                    mode_in,
    input  logic [23:0]                   camera_pixel_in,
    input  logic [7:0]                    sel_channel_in,
    input  logic [1:0]                    thr_in,
    input  logic [24*NUM_LAYERS-1:0]      layer_pixel_in,
    input  logic [NUM_LAYERS-1:0]         layer_valid_in,
    input  logic [ALPHA_W*NUM_LAYERS-1:0] layer_alpha_in,
    input  logic [NUM_LAYERS-1:0]         layer_en_in,
    input  logic [NUM_LAYERS-1:0]         blink_en_in,
    input  logic                          frame_start_in,
    input  logic [SYNC_W-1:0]             sync_in,
    output logic [23:0]                   pixel_out,
    output logic [SYNC_W-1:0]             sync_out,
    output logic                          blink_phase_out
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int LW    = 24 * NUM_LAYERS;
    localparam int AWN   = ALPHA_W * NUM_LAYERS;

    function automatic logic [7:0] blend_ch(input logic [7:0] fg, input logic [7:0] bg,
                                            input logic [ALPHA_W-1:0] a);
`ifdef COMPOSITOR_ALPHA_EN
        localparam int ACC_W = ALPHA_W + 9;
        localparam logic [ALPHA_W-1:0] AMAX = '1;
        logic [ACC_W-1:0] acc;
        if (a == AMAX) return fg;
        // a == 0 degenerates to bg, so inactive layers need no special case
        acc = ACC_W'(a) * ACC_W'(fg) + (ACC_W'(2**ALPHA_W) - ACC_W'(a)) * ACC_W'(bg);
        return acc[ALPHA_W +: 8];
`else
        return (a != '0) ? fg : bg;
`endif
    endfunction

    function automatic logic [23:0] blend_px(input logic [23:0] fg, input logic [23:0] bg,
                                             input logic [ALPHA_W-1:0] a);
        return {blend_ch(fg[23:16], bg[23:16], a), blend_ch(fg[15:8], bg[15:8], a),
                blend_ch(fg[7:0], bg[7:0], a)};
    endfunction

    logic                  fs;
    logic [1:0]            mode_q, mode_d;
    logic [NUM_LAYERS-1:0] en_q, en_d, blk_q, blk_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    logic [23:0]           pix_q  [0:NUM_LAYERS];
    logic [23:0]           pix_d  [0:NUM_LAYERS];
    logic [SYNC_W-1:0]     sync_q [0:NUM_LAYERS];
    logic [SYNC_W-1:0]     sync_d [0:NUM_LAYERS];
    logic [LW-1:0]         lp_q   [0:NUM_LAYERS-1];
    logic [LW-1:0]         lp_d   [0:NUM_LAYERS-1];
    logic [AWN-1:0]        la_q   [0:NUM_LAYERS-1];
    logic [AWN-1:0]        la_d   [0:NUM_LAYERS-1];

    // Shadows and blink state; the _d values double as the bypass for the frame_start pixel
    assign fs = frame_start_in & rst_n_in;

    always_comb begin
        mode_d  = fs ? mode_in : mode_q;
        en_d    = fs ? layer_en_in : en_q;
        blk_d   = fs ? blink_en_in : blk_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (fs) begin
            if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stage 0: base pixel, layer activity folded into the alpha (inactive => alpha 0)
    always_comb begin
        unique case (mode_d)
            2'd0:    pix_d[0] = camera_pixel_in;
            2'd1:    pix_d[0] = thr_in[0] ? 24'h00FFFF :
                                thr_in[1] ? 24'hFF77AA : {3{sel_channel_in}};
            2'd2:    pix_d[0] = {3{sel_channel_in}};
            default: pix_d[0] = 24'h000000;
        endcase
        sync_d[0] = sync_in;
        lp_d[0]   = layer_pixel_in;
        la_d[0]   = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_valid_in[i] && en_d[i] && (!blk_d[i] || phase_d))
                la_d[0][ALPHA_W*i +: ALPHA_W] = layer_alpha_in[ALPHA_W*i +: ALPHA_W];
        end
        for (int s = 1; s < NUM_LAYERS; s++) begin
            lp_d[s] = lp_q[s-1];
            la_d[s] = la_q[s-1];
        end
        // Stages 1..N: stage k blends layer N-k over the previous stage's result
        for (int k = 1; k <= NUM_LAYERS; k++) begin
            sync_d[k] = sync_q[k-1];
            pix_d[k]  = blend_px(lp_q[k-1][24*(NUM_LAYERS-k) +: 24], pix_q[k-1],
                                 la_q[k-1][ALPHA_W*(NUM_LAYERS-k) +: ALPHA_W]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            mode_q  <= 2'd0;
            en_q    <= '0;
            blk_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            for (int k = 0; k <= NUM_LAYERS; k++) begin
                pix_q[k]  <= '0;
                sync_q[k] <= '0;
            end
            for (int s = 0; s < NUM_LAYERS; s++) begin
                lp_q[s] <= '0;
                la_q[s] <= '0;
            end
        end else begin
            mode_q  <= mode_d;
            en_q    <= en_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            for (int k = 0; k <= NUM_LAYERS; k++) begin
                pix_q[k]  <= pix_d[k];
                sync_q[k] <= sync_d[k];
            end
            for (int s = 0; s < NUM_LAYERS; s++) begin
                lp_q[s] <= lp_d[s];
                la_q[s] <= la_d[s];
            end
        end
    end

    assign pixel_out       = pix_q[NUM_LAYERS];
    assign sync_out        = sync_q[NUM_LAYERS];
    assign blink_phase_out = phase_d;

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: directed vector table, hand sequences and a per-cycle reference model.
module tb_layer_compositor;
    localparam int N = 4, AW = 4, SW = 3, BF = 2, L = N + 1, AMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [1:0]    mode = '0, thr = '0;
    logic [23:0]   cam = '0;
    logic [7:0]    y = '0;
    logic [24*N-1:0] lpix = '0;
    logic [N-1:0]  lval = '0, len = '0, ben = '0;
    logic [AW*N-1:0] lalpha = '0;
    logic          fs = 1'b0;
    logic [SW-1:0] sync = '0;
    logic [23:0]   pixel_out;
    logic [SW-1:0] sync_out;
    logic          blink_phase_out;

    layer_compositor #(.NUM_LAYERS(N), .ALPHA_W(AW), .SYNC_W(SW), .BLINK_FRAMES(BF)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .camera_pixel_in(cam),
        .sel_channel_in(y), .thr_in(thr), .layer_pixel_in(lpix), .layer_valid_in(lval),
        .layer_alpha_in(lalpha), .layer_en_in(len), .blink_en_in(ben),
        .frame_start_in(fs), .sync_in(sync), .pixel_out(pixel_out), .sync_out(sync_out),
        .blink_phase_out(blink_phase_out));

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: shadow state, frame counter and an L-deep output history
    logic [1:0]    m_mode = '0;
    logic [N-1:0]  m_en = '0, m_blk = '0;
    int            m_cnt = 0;
    bit            m_phase = 1'b1;
    logic [23:0]   pp [L];
    logic [SW-1:0] ps [L];

    function automatic int blend8(input int fg, input int bg, input int a);
`ifdef COMPOSITOR_ALPHA_EN
        if (a == AMAX) return fg;
        return (a * fg + ((1 << AW) - a) * bg) / (1 << AW);
`else
        return fg;
`endif
    endfunction

    function automatic bit model_phase();
        bit efs = fs && rst_n;
        return (efs && m_cnt == BF - 1) ? !m_phase : m_phase;
    endfunction

    function automatic logic [23:0] model_px();
        bit efs = fs && rst_n;
        logic [1:0] md = efs ? mode : m_mode;
        logic [N-1:0] en = efs ? len : m_en;
        logic [N-1:0] bk = efs ? ben : m_blk;
        bit ph = model_phase();
        logic [23:0] px;
        case (md)
            2'd0: px = cam;
            2'd1: px = thr[0] ? 24'h00FFFF : (thr[1] ? 24'hFF77AA : {y, y, y});
            2'd2: px = {y, y, y};
            default: px = 24'h0;
        endcase
        for (int i = N - 1; i >= 0; i--) begin
            int a = int'(lalpha[i*AW +: AW]);
            if (lval[i] && en[i] && a != 0 && (!bk[i] || ph))
                for (int c = 0; c < 3; c++)
                    px[c*8 +: 8] = 8'(blend8(int'(lpix[i*24 + c*8 +: 8]), int'(px[c*8 +: 8]), a));
        end
        return px;
    endfunction

    task automatic step();
        logic [23:0] ep;
        bit eph;
        ep  = model_px();
        eph = model_phase();
        #1;
        if (rst_n) check("blink_phase", blink_phase_out, eph);
        @(posedge clk);
        if (!rst_n) begin
            m_mode = '0; m_en = '0; m_blk = '0; m_cnt = 0; m_phase = 1'b1;
            for (int i = 0; i < L; i++) begin pp[i] = '0; ps[i] = '0; end
        end else begin
            for (int i = L - 1; i > 0; i--) begin pp[i] = pp[i-1]; ps[i] = ps[i-1]; end
            pp[0] = ep;
            ps[0] = sync;
            if (fs) begin
                m_mode = mode; m_en = len; m_blk = ben; m_phase = eph;
                m_cnt = (m_cnt == BF - 1) ? 0 : m_cnt + 1;
            end
        end
        #1;
        check("model_pixel", pixel_out, pp[L-1]);
        check("model_sync", sync_out, ps[L-1]);
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mode, thr;
        logic [23:0] cam;
        logic [7:0]  y;
        logic [23:0] l0, l2;
        logic        v0, v2;
        logic [3:0]  a;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [11];

    initial begin
        for (int i = 0; i < L; i++) begin pp[i] = '0; ps[i] = '0; end
        tbl[0]  = '{"base_camera", 2'd0, 2'b00, 24'h123456, 8'h40, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'h123456};
        tbl[1]  = '{"thr_both",    2'd1, 2'b11, 24'h123456, 8'h40, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'h00FFFF};
        tbl[2]  = '{"thr_bit1",    2'd1, 2'b10, 24'h123456, 8'h40, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'hFF77AA};
        tbl[3]  = '{"thr_none",    2'd1, 2'b00, 24'h123456, 8'h40, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'h404040};
        tbl[4]  = '{"gray",        2'd2, 2'b11, 24'h123456, 8'h9A, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'h9A9A9A};
        tbl[5]  = '{"black",       2'd3, 2'b11, 24'h123456, 8'h9A, 24'h0, 24'h0, 1'b0, 1'b0, 4'hF, 24'h000000};
        tbl[6]  = '{"prio_l0_top", 2'd3, 2'b00, 24'h0, 8'h0, 24'hFF0000, 24'h00FF00, 1'b1, 1'b1, 4'hF, 24'hFF0000};
        tbl[7]  = '{"prio_l2",     2'd3, 2'b00, 24'h0, 8'h0, 24'hFF0000, 24'h00FF00, 1'b0, 1'b1, 4'hF, 24'h00FF00};
`ifdef COMPOSITOR_ALPHA_EN
        tbl[8]  = '{"alpha_8",     2'd3, 2'b00, 24'h0, 8'h0, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 4'h8, 24'h7F7F7F};
`else
        tbl[8]  = '{"alpha_8",     2'd3, 2'b00, 24'h0, 8'h0, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 4'h8, 24'hFFFFFF};
`endif
        tbl[9]  = '{"alpha_max",   2'd3, 2'b00, 24'h0, 8'h0, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 4'hF, 24'hFFFFFF};
        tbl[10] = '{"alpha_0",     2'd3, 2'b00, 24'h0, 8'h0, 24'hFFFFFF, 24'h0, 1'b1, 1'b0, 4'h0, 24'h000000};

        // Reset and latency ramp
        rst_n = 1'b0;
        repeat (3) begin
            step();
            check("reset_pixel", pixel_out, 0);
            check("reset_sync", sync_out, 0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cam  = 24'(j + 1);
            sync = SW'(j + 1);
            step();
            check("latency_ramp", pixel_out, (j >= L - 1) ? j - L + 2 : 0);
        end

        // Directed vectors, each captured by a frame_start pulse
        for (int i = 0; i < 11; i++) begin
            mode = tbl[i].mode; thr = tbl[i].thr; cam = tbl[i].cam; y = tbl[i].y;
            lpix = '0;
            lpix[23:0]  = tbl[i].l0;
            lpix[71:48] = tbl[i].l2;
            lval = {1'b0, tbl[i].v2, 1'b0, tbl[i].v0};
            lalpha = {N{tbl[i].a}};
            len = '1; ben = '0; fs = 1'b1;
            step();
            fs = 1'b0;
            repeat (L - 1) step();
            check(tbl[i].name, pixel_out, tbl[i].exp);
        end

        // Shadowing: mid-frame mode change waits for the next frame_start
        lval = '0; mode = 2'd0; cam = 24'hAABBCC; fs = 1'b1;
        step();
        fs = 1'b0; mode = 2'd1; thr = 2'b11;
        repeat (L + 2) step();
        check("shadow_hold", pixel_out, 24'hAABBCC);
        fs = 1'b1;
        step();
        fs = 1'b0;
        repeat (L - 1) step();
        check("shadow_apply", pixel_out, 24'h00FFFF);

        // Blink with BLINK_FRAMES=2
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mode = 2'd3; cam = '0; lpix = '0; lpix[23:0] = 24'hFF0000; lval = 4'b0001;
        lalpha = '1; len = 4'b0001; ben = 4'b0001;
        repeat (L + 1) step();
        check("blink_f0_disabled", pixel_out, 0);
        check("blink_f0_phase", blink_phase_out, 1);
        for (int f = 1; f <= 4; f++) begin
            fs = 1'b1;
            step();
            fs = 1'b0;
            repeat (L + 1) step();
            check("blink_frame_pixel", pixel_out, (f == 1 || f == 4) ? 24'hFF0000 : 24'h0);
            check("blink_frame_phase", blink_phase_out, (f == 1 || f == 4) ? 1 : 0);
        end

        // Mid-stream reset
        mode = 2'd2; y = 8'h33; len = '1; ben = '0; lval = '1; fs = 1'b1;
        lpix = {$urandom(), $urandom(), $urandom()};
        lalpha = 16'h8F3A;
        step();
        fs = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        check("midrst_pixel", pixel_out, 0);
        check("midrst_sync", sync_out, 0);
        check("midrst_phase", blink_phase_out, 1);
        rst_n = 1'b1; mode = 2'd3; cam = 24'h123456; sync = 3'd5; lalpha = '1;
        repeat (L) step();
        check("midrst_shadow_mode", pixel_out, 24'h123456);
        check("midrst_sync_out", sync_out, 5);

        // Randomised stream against the model
        repeat (400) begin
            mode = 2'($urandom()); thr = 2'($urandom()); cam = 24'($urandom());
            y = 8'($urandom()); lpix = {$urandom(), $urandom(), $urandom()};
            lval = 4'($urandom()); lalpha = 16'($urandom());
            if ($urandom_range(0, 3) == 0) lalpha[3:0] = 4'hF;
            len = 4'($urandom()); ben = 4'($urandom()); sync = 3'($urandom());
            fs = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            step();
        end
        rst_n = 1'b1; fs = 1'b0;
        repeat (L) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
